// File: rtl/gs_mixer.sv
// Time-multiplexed N-channel stereo mixer for the General Sound outputs.
// Accumulates one channel per clock with per-side gains and emits a saturated sample per frame.
module gs_mixer #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 9,
    parameter int GAIN_W   = 6
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         ce,
    input  logic [CHANNELS*IN_W-1:0]     in_data,
    input  logic                         cfg_we,
    input  logic [$clog2(CHANNELS)-1:0]  cfg_ch,
    input  logic                         cfg_side,
    input  logic [GAIN_W-1:0]            cfg_gain,
    output logic [OUT_W-1:0]             out_l,
    output logic [OUT_W-1:0]             out_r,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CH_W = $clog2(CHANNELS);
    localparam int AW   = IN_W + GAIN_W + CH_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << (GAIN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_OUT} state_t;

    state_t                    state_q;
    logic [CH_W-1:0]           idx_q;
    logic [CHANNELS*IN_W-1:0]  samp_q;
    logic [GAIN_W-1:0]         pend_l_q [CHANNELS];
    logic [GAIN_W-1:0]         pend_r_q [CHANNELS];
    logic [GAIN_W-1:0]         pend_l_d [CHANNELS];
    logic [GAIN_W-1:0]         pend_r_d [CHANNELS];
    logic [GAIN_W-1:0]         act_l_q  [CHANNELS];
    logic [GAIN_W-1:0]         act_r_q  [CHANNELS];
    logic [AW-1:0]             acc_l_q, acc_r_q;
    logic [OUT_W-1:0]          out_l_q, out_r_q;
    logic                      valid_q, busy_q, ovr_q;

    logic [IN_W-1:0]           cur_s;
    logic [AW-1:0]             prod_l, prod_r;
    logic [AW-1:0]             v_l, v_r;

    // Same-cycle writes feed the active bank directly so a write on the accepting ce counts.
    always_comb begin
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cfg_we && cfg_ch == CH_W'(c)) begin
                if (cfg_side) pend_r_d[c] = cfg_gain;
                else          pend_l_d[c] = cfg_gain;
            end
        end
    end

    always_comb begin
        cur_s  = samp_q[idx_q*IN_W +: IN_W];
        prod_l = AW'(cur_s) * AW'(act_l_q[idx_q]);
        prod_r = AW'(cur_s) * AW'(act_r_q[idx_q]);
        v_l    = acc_l_q >> (GAIN_W - 1);
        v_r    = acc_r_q >> (GAIN_W - 1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            samp_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                pend_l_q[c] <= (c < CHANNELS / 2) ? UNITY : '0;
                pend_r_q[c] <= (c < CHANNELS / 2) ? '0 : UNITY;
                act_l_q[c]  <= (c < CHANNELS / 2) ? UNITY : '0;
                act_r_q[c]  <= (c < CHANNELS / 2) ? '0 : UNITY;
            end
        end else begin
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            valid_q  <= 1'b0;
            if (ce && busy_q) ovr_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (ce) begin
                        samp_q  <= in_data;
                        act_l_q <= pend_l_d;
                        act_r_q <= pend_r_d;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    acc_l_q <= acc_l_q + prod_l;
                    acc_r_q <= acc_r_q + prod_r;
                    idx_q   <= idx_q + CH_W'(1);
                    if (idx_q == CH_W'(CHANNELS - 1)) state_q <= S_OUT;
                end
                S_OUT: begin
                    // Any bit above OUT_W after the gain shift means clip to full scale.
                    out_l_q <= (|(v_l >> OUT_W)) ? '1 : v_l[OUT_W-1:0];
                    out_r_q <= (|(v_r >> OUT_W)) ? '1 : v_r[OUT_W-1:0];
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_gs_mixer.sv
// Self-checking bench for gs_mixer: directed cases plus random frames against a gain/sum model.
module tb_gs_mixer;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce      = 1'b0;
    logic [31:0] in_data = '0;
    logic        cfg_we  = 1'b0;
    logic [1:0]  cfg_ch  = '0;
    logic        cfg_side = 1'b0;
    logic [5:0]  cfg_gain = '0;
    logic [8:0]  out_l, out_r;
    logic        out_valid, busy, overrun;

    int n_chk = 0;
    int n_err = 0;

    int pl [4], pr [4];
    int al [4], ar [4];
    int snap [4];

    gs_mixer #(.CHANNELS(4), .IN_W(8), .OUT_W(9), .GAIN_W(6)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_side  (cfg_side),
        .cfg_gain  (cfg_gain),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model_defaults();
        for (int c = 0; c < 4; c++) begin
            pl[c] = (c < 2) ? 32 : 0;
            pr[c] = (c < 2) ? 0 : 32;
        end
    endtask

    // Stereo mix of the snapshotted frame: weighted sum, divide by unity, clip to 9 bits.
    task automatic mix(output int l, output int r);
        int sl = 0, sr = 0;
        for (int c = 0; c < 4; c++) begin
            sl += snap[c] * al[c];
            sr += snap[c] * ar[c];
        end
        l = sl / 32;
        r = sr / 32;
        if (l > 511) l = 511;
        if (r > 511) r = 511;
    endtask

    task automatic set_pending(input int ch, input int side, input int g);
        if (side != 0) pr[ch] = g;
        else           pl[ch] = g;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_defaults();
    endtask

    task automatic cfg_write(input int ch, input int side, input int g);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_side = side[0];
        cfg_gain = 6'(g);
        tick();
        cfg_we   = 1'b0;
        set_pending(ch, side, g);
    endtask

    task automatic start_frame(input logic [31:0] d, input bit wr, input int ch, input int side, input int g);
        in_data = d;
        ce      = 1'b1;
        if (wr) begin
            cfg_we   = 1'b1;
            cfg_ch   = 2'(ch);
            cfg_side = side[0];
            cfg_gain = 6'(g);
            set_pending(ch, side, g);
        end
        for (int c = 0; c < 4; c++) begin
            al[c]   = pl[c];
            ar[c]   = pr[c];
            snap[c] = int'((d >> (8 * c)) & 32'hFF);
        end
        tick();
        ce      = 1'b0;
        cfg_we  = 1'b0;
        in_data = $urandom;
    endtask

    task automatic finish_frame(input string tag, input int exp_lat);
        int lat = 0;
        bit bz  = 1'b1;
        int el, er;
        mix(el, er);
        while (!out_valid && lat < 30) begin
            if (!busy) bz = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, 32'(bz), 1);
        check({tag, "_l"}, 32'(out_l), el);
        check({tag, "_r"}, 32'(out_r), er);
        tick();
        check({tag, "_vdrop"}, {30'd0, out_valid, busy}, 0);
    endtask

    initial begin
        logic [31:0] d;
        int nv;
        model_defaults();
        tick();
        tick();
        reset = 1'b0;

        check("rst_l", 32'(out_l), 0);
        check("rst_r", 32'(out_r), 0);
        check("rst_flags", {29'd0, out_valid, busy, overrun}, 0);

        // Defaults: left = ch0+ch1, right = ch2+ch3.
        start_frame(32'h2010_4080, 1'b0, 0, 0, 0);
        finish_frame("dflt", 5);
        check("dflt_l_const", 32'(out_l), 32'h0C0);
        check("dflt_r_const", 32'(out_r), 32'h030);

        // Saturation on the left side.
        for (int c = 0; c < 4; c++) cfg_write(c, 0, 63);
        start_frame(32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        finish_frame("sat", 5);
        check("sat_l_const", 32'(out_l), 511);
        check("sat_r_const", 32'(out_r), 510);

        // Centre pan of ch0.
        for (int c = 1; c < 4; c++) begin
            cfg_write(c, 0, 0);
            cfg_write(c, 1, 0);
        end
        cfg_write(0, 0, 16);
        cfg_write(0, 1, 16);
        d = $urandom;
        d[7:0] = 8'hFF;
        start_frame(d, 1'b0, 0, 0, 0);
        finish_frame("pan", 5);
        check("pan_l_const", 32'(out_l), 127);
        check("pan_r_const", 32'(out_r), 127);

        // Gain write timing relative to frames.
        reset_pulse();
        start_frame(32'h2010_4080, 1'b0, 0, 0, 0);
        cfg_write(0, 0, 0);
        finish_frame("cfg_busy", 4);
        check("cfg_busy_const", 32'(out_l), 32'h0C0);
        start_frame(32'h2010_4080, 1'b0, 0, 0, 0);
        finish_frame("cfg_next", 5);
        check("cfg_next_const", 32'(out_l), 32'h040);
        start_frame(32'h2010_4080, 1'b1, 0, 0, 32);
        finish_frame("cfg_same", 5);
        check("cfg_same_const", 32'(out_l), 32'h0C0);
        check("ovr_none", 32'(overrun), 0);

        // Second ce two clocks into a frame.
        start_frame(32'h1122_3344, 1'b0, 0, 0, 0);
        tick();
        ce = 1'b1;
        tick();
        ce = 1'b0;
        finish_frame("ovr", 3);
        check("ovr_set", 32'(overrun), 1);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) nv++;
            tick();
        end
        check("ovr_single_valid", nv, 0);
        check("ovr_hold_l", 32'(out_l), 32'h077);
        check("ovr_sticky", 32'(overrun), 1);

        // Reset while summing channel 2.
        cfg_write(1, 1, 40);
        start_frame(32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_defaults();
        check("rmid_l", 32'(out_l), 0);
        check("rmid_r", 32'(out_r), 0);
        check("rmid_flags", {29'd0, out_valid, busy, overrun}, 0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) nv++;
            tick();
        end
        check("rmid_no_valid", nv, 0);
        start_frame(32'h2010_4080, 1'b0, 0, 0, 0);
        finish_frame("rmid_dflt", 5);
        check("rmid_dflt_r_const", 32'(out_r), 32'h030);

        // Random gains, samples and same-cycle writes.
        for (int f = 0; f < 30; f++) begin
            int k;
            k = $urandom_range(0, 3);
            for (int w = 0; w < k; w++)
                cfg_write($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 63));
            start_frame($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                        $urandom_range(0, 1), $urandom_range(0, 63));
            finish_frame($sformatf("rnd%0d", f), 5);
        end
        check("rnd_ovr", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
